// File: rtl/mmio_periph_hub_pkg.sv
// Shared parameters and register-offset encoding for the MMIO peripheral hub.
package common_params;

    localparam int BITS            = 32;
    localparam int DONE_STICKY_BIT = 8;

    typedef enum logic [2:0] {
        REG_LED        = 3'd0,
        REG_SW         = 3'd1,
        REG_KEY        = 3'd2,
        REG_KEY_EDGE   = 3'd3,
        REG_COPROC_CTL = 3'd4,
        REG_COPROC_STS = 3'd5,
        REG_IRQ_MASK   = 3'd6,
        REG_CYCLE      = 3'd7
    } reg_off_e;

endpackage

// File: rtl/mmio_periph_hub_debounce.sv
// Per-key synchroniser, optional debounce filter (MMIO_DEBOUNCE_EN) and press (1->0) detector.
module mmio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic fall_o
);
    import common_params::*;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("mmio_debounce: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    logic                   prev_q;

    // Keys idle high, so the chain resets to "released" and reset release is never a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CntW-1:0] cnt_q;
    logic            filt_q;

    // Any cycle where the input agrees with the filtered level restarts the run count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                filt_q <= sync_q[SYNC_STAGES-1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign fall_o  = prev_q & ~level;

endmodule

// File: rtl/mmio_periph_hub.sv
// Memory-mapped LED/switch/key/coprocessor/IRQ/cycle-counter block; key debounce enabled by MMIO_DEBOUNCE_EN.
module mmio_periph_hub #(
    parameter int               BITS            = common_params::BITS,
    parameter logic [BITS-1:0]  BASE_ADDR       = 'hFFFF_FFF0,
    parameter int               NUM_LED         = 10,
    parameter int               NUM_SW          = 10,
    parameter int               NUM_KEY         = 4,
    parameter int               STS_W           = 2,
    parameter int               DONE_BIT        = 1,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BITS-1:0]     io_addr,
    input  logic [BITS-1:0]     io_wdata,
    input  logic                io_wen,
    input  logic                io_rden,
    output logic [BITS-1:0]     io_rdata,
    input  logic [NUM_SW-1:0]   sw,
    input  logic [NUM_KEY-1:0]  key,
    output logic [NUM_LED-1:0]  ledr,
    output logic [7:0]          coproc_ctl,
    input  logic [STS_W-1:0]    coproc_sts,
    output logic                irq
);
    import common_params::*;

    logic [BITS-1:0]    offsetFull;
    logic               addrHit;
    reg_off_e           offset;

    logic               ledWr;
    logic               keyEdgeWr;
    logic               ctlWr;
    logic               stsWr;
    logic               maskWr;
    logic               cycleWr;

    logic [NUM_LED-1:0] led_q;
    logic [NUM_SW-1:0]  swSync_q [SYNC_STAGES];
    logic [NUM_KEY-1:0] keyLevel;
    logic [NUM_KEY-1:0] keyFall;
    logic [NUM_KEY-1:0] keyEdge_q,    keyEdge_d;
    logic               stsDone_q;
    logic               doneSticky_q, doneSticky_d;
    logic [NUM_KEY:0]   irqMask_q;
    logic [BITS-1:0]    cycle_q,      cycle_d;
    logic               irq_q;
    logic [BITS-1:0]    rdData;

    // Modular subtraction makes the hit test a single upper-bits-zero compare.
    assign offsetFull = io_addr - BASE_ADDR;
    assign addrHit    = (offsetFull[BITS-1:3] == '0);
    assign offset     = reg_off_e'(offsetFull[2:0]);

    assign ledWr     = io_wen && addrHit && (offset == REG_LED);
    assign keyEdgeWr = io_wen && addrHit && (offset == REG_KEY_EDGE);
    assign ctlWr     = io_wen && addrHit && (offset == REG_COPROC_CTL);
    assign stsWr     = io_wen && addrHit && (offset == REG_COPROC_STS);
    assign maskWr    = io_wen && addrHit && (offset == REG_IRQ_MASK);
    assign cycleWr   = io_wen && addrHit && (offset == REG_CYCLE);

    for (genvar g = 0; g < NUM_KEY; g++) begin : g_key
        mmio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key (
            .clk     (clk),
            .rst_n   (rst_n),
            .async_i (key[g]),
            .level_o (keyLevel[g]),
            .fall_o  (keyFall[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                swSync_q[i] <= '0;
            end
        end else begin
            swSync_q[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                swSync_q[i] <= swSync_q[i-1];
            end
        end
    end

    // Sticky bits apply the W1C clear first and the new event second, so a same-cycle set wins.
    always_comb begin
        keyEdge_d = keyEdge_q;
        if (keyEdgeWr) begin
            keyEdge_d = keyEdge_d & ~io_wdata[NUM_KEY-1:0];
        end
        keyEdge_d = keyEdge_d | keyFall;

        doneSticky_d = doneSticky_q;
        if (stsWr && io_wdata[DONE_STICKY_BIT]) begin
            doneSticky_d = 1'b0;
        end
        if (coproc_sts[DONE_BIT] && !stsDone_q) begin
            doneSticky_d = 1'b1;
        end

        cycle_d = cycleWr ? io_wdata : cycle_q + BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q        <= '0;
            keyEdge_q    <= '0;
            stsDone_q    <= 1'b0;
            doneSticky_q <= 1'b0;
            irqMask_q    <= '0;
            cycle_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            if (ledWr) begin
                led_q <= io_wdata[NUM_LED-1:0];
            end
            if (maskWr) begin
                irqMask_q <= io_wdata[NUM_KEY:0];
            end
            keyEdge_q    <= keyEdge_d;
            stsDone_q    <= coproc_sts[DONE_BIT];
            doneSticky_q <= doneSticky_d;
            cycle_q      <= cycle_d;
            irq_q        <= |({doneSticky_q, keyEdge_q} & irqMask_q);
        end
    end

    always_comb begin
        rdData = '0;
        if (io_rden && addrHit) begin
            case (offset)
                REG_LED:        rdData[NUM_LED-1:0] = led_q;
                REG_SW:         rdData[NUM_SW-1:0]  = swSync_q[SYNC_STAGES-1];
                REG_KEY:        rdData[NUM_KEY-1:0] = keyLevel;
                REG_KEY_EDGE:   rdData[NUM_KEY-1:0] = keyEdge_q;
                REG_COPROC_STS: begin
                    rdData[STS_W-1:0]      = coproc_sts;
                    rdData[DONE_STICKY_BIT] = doneSticky_q;
                end
                REG_IRQ_MASK:   rdData[NUM_KEY:0]   = irqMask_q;
                REG_CYCLE:      rdData              = cycle_q;
                default:        rdData              = '0;
            endcase
        end
    end

    assign io_rdata   = rdData;
    assign ledr       = led_q;
    assign coproc_ctl = ctlWr ? io_wdata[7:0] : 8'h00;
    assign irq        = irq_q;

endmodule

// File: tb/tb_mmio_periph_hub.sv
// Scoreboard bench for mmio_periph_hub: stimulus queues expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mmio_periph_hub;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic        io_wen = 1'b0;
    logic        io_rden = 1'b0;
    logic [31:0] io_rdata;
    logic [9:0]  sw = '0;
    logic [3:0]  key = 4'hF;
    logic [9:0]  ledr;
    logic [7:0]  coproc_ctl;
    logic [1:0]  coproc_sts = '0;
    logic        irq;

    typedef enum int {K_RDATA, K_LED, K_CTL, K_IRQ} kind_e;
    typedef struct {
        kind_e       kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    logic obsReq = 1'b0;

    always #5 clk = ~clk;

    mmio_periph_hub #(
        .BITS            (32),
        .BASE_ADDR       (32'hFFFF_FFF0),
        .NUM_LED         (10),
        .NUM_SW          (10),
        .NUM_KEY         (4),
        .STS_W           (2),
        .DONE_BIT        (1),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_wen     (io_wen),
        .io_rden    (io_rden),
        .io_rdata   (io_rdata),
        .sw         (sw),
        .key        (key),
        .ledr       (ledr),
        .coproc_ctl (coproc_ctl),
        .coproc_sts (coproc_sts),
        .irq        (irq)
    );

    // Monitor: every presented read or observation strobe consumes one queued expectation.
    task automatic scoreOne();
        exp_t        e;
        logic [31:0] act;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard-underflow: output presented, got 0x%08h with no expected value", io_rdata);
            return;
        end
        e = expQ.pop_front();
        case (e.kind)
            K_RDATA: act = io_rdata;
            K_LED:   act = 32'(ledr);
            K_CTL:   act = 32'(coproc_ctl);
            default: act = 32'(irq);
        endcase
        if (act !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
    endtask

    always @(negedge clk) begin
        if (io_rden) scoreOne();
        if (obsReq)  scoreOne();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        io_addr  = addr;
        io_wdata = data;
        io_wen   = 1'b1;
        tick();
        io_wen   = 1'b0;
    endtask

    task automatic readCheck(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e = '{K_RDATA, name, exp};
        expQ.push_back(e);
        io_addr = addr;
        io_rden = 1'b1;
        tick();
        io_rden = 1'b0;
    endtask

    task automatic checkOutput(input kind_e kind, input logic [31:0] exp, input string name);
        exp_t e;
        e = '{kind, name, exp};
        expQ.push_back(e);
        obsReq = 1'b1;
        tick();
        obsReq = 1'b0;
    endtask

    task automatic applyStimulus();
        // Reset state, sampled while rst_n is still low
        tick();
        tick();
        readCheck(BASE + 7, 32'h0, "cycle-in-reset");
        readCheck(BASE + 3, 32'h0, "key-edge-reset");
        readCheck(BASE + 6, 32'h0, "mask-reset");
        readCheck(BASE + 5, 32'h0, "sts-reset");
        readCheck(BASE + 2, 32'hF, "key-sync-reset");
        checkOutput(K_LED, 32'h0, "led-reset");
        checkOutput(K_IRQ, 32'h0, "irq-reset");
        checkOutput(K_CTL, 32'h0, "ctl-reset");
        rst_n = 1'b1;
        readCheck(BASE + 7, 32'h0, "cycle-after-reset");
        readCheck(BASE + 7, 32'h1, "cycle-increment");

        // LED register and decode
        busWrite(BASE, 32'h3FF);
        checkOutput(K_LED, 32'h3FF, "led-write");
        readCheck(BASE, 32'h3FF, "led-read");
        io_addr  = BASE;
        io_wdata = 32'h0;
        tick();
        checkOutput(K_LED, 32'h3FF, "led-no-wen");
        busWrite(32'hFFFF_FFF8, 32'h0);
        readCheck(BASE, 32'h3FF, "led-unmapped-write");
        io_addr = BASE;
        checkOutput(K_RDATA, 32'h0, "rdata-no-rden");
        readCheck(32'hFFFF_FFF8, 32'h0, "unmapped-read-above");
        readCheck(32'hFFFF_FFEF, 32'h0, "unmapped-read-below");
        readCheck(BASE + 4, 32'h0, "wo-ctl-read");

        // Switch synchroniser latency
        sw = 10'h155;
        readCheck(BASE + 1, 32'h0,   "sw-sync-0");
        readCheck(BASE + 1, 32'h0,   "sw-sync-1");
        readCheck(BASE + 1, 32'h155, "sw-sync-2");

`ifdef MMIO_DEBOUNCE_EN
        // Bounce of 5 low, 1 high, then a clean low run of 8 filtered cycles
        key = 4'hE;
        repeat (5) tick();
        key = 4'hF;
        tick();
        key = 4'hE;
        repeat (9) tick();
        readCheck(BASE + 2, 32'hF, "db-level-before");
        readCheck(BASE + 3, 32'h0, "db-edge-before");
        readCheck(BASE + 3, 32'h1, "db-edge-set");
        readCheck(BASE + 2, 32'hE, "db-level-after");
        busWrite(BASE + 3, 32'h1);
        repeat (3) tick();
        readCheck(BASE + 3, 32'h0, "db-single-edge");
        key = 4'hF;
        repeat (12) tick();
`else
        // Key latency, edge capture, masking and W1C collision
        key = 4'hB;
        readCheck(BASE + 2, 32'hF, "key-lat-0");
        readCheck(BASE + 2, 32'hF, "key-lat-1");
        readCheck(BASE + 2, 32'hB, "key-lat-2");
        readCheck(BASE + 3, 32'h4, "key-edge-set");
        checkOutput(K_IRQ, 32'h0, "irq-masked");
        busWrite(BASE + 6, 32'h4);
        checkOutput(K_IRQ, 32'h0, "irq-reg-delay");
        checkOutput(K_IRQ, 32'h1, "irq-key");
        key = 4'hF;
        repeat (4) tick();
        key = 4'hB;
        tick();
        tick();
        busWrite(BASE + 3, 32'h4);
        readCheck(BASE + 3, 32'h4, "w1c-collision");
        busWrite(BASE + 3, 32'h4);
        readCheck(BASE + 3, 32'h0, "w1c-clear");
        checkOutput(K_IRQ, 32'h0, "irq-after-clear");
        key = 4'hF;
        repeat (3) tick();
`endif

        // Coprocessor start pulses, back to back
        io_addr  = BASE + 4;
        io_wdata = 32'h81;
        io_wen   = 1'b1;
        checkOutput(K_CTL, 32'h81, "ctl-pulse-0");
        checkOutput(K_CTL, 32'h81, "ctl-pulse-1");
        io_wen   = 1'b0;
        checkOutput(K_CTL, 32'h0, "ctl-idle");

        // Done sticky flag and its interrupt
        coproc_sts = 2'd2;
        readCheck(BASE + 5, 32'h002, "sts-before-done");
        readCheck(BASE + 5, 32'h102, "sts-done");
        busWrite(BASE + 5, 32'h100);
        readCheck(BASE + 5, 32'h002, "sts-w1c");
        busWrite(BASE + 6, 32'h10);
        coproc_sts = 2'd0;
        tick();
        tick();
        checkOutput(K_IRQ, 32'h0, "irq-done-idle");
        coproc_sts = 2'd2;
        checkOutput(K_IRQ, 32'h0, "irq-done-c0");
        checkOutput(K_IRQ, 32'h0, "irq-done-delay");
        checkOutput(K_IRQ, 32'h1, "irq-done");
        busWrite(BASE + 5, 32'h100);
        checkOutput(K_IRQ, 32'h1, "irq-done-hold");
        checkOutput(K_IRQ, 32'h0, "irq-done-clear");
        coproc_sts = 2'd0;
        readCheck(BASE + 6, 32'h10, "mask-read");

        // Cycle counter load and wrap
        busWrite(BASE + 7, 32'hFFFF_FFFE);
        readCheck(BASE + 7, 32'hFFFF_FFFE, "cycle-load");
        readCheck(BASE + 7, 32'hFFFF_FFFF, "cycle-max");
        readCheck(BASE + 7, 32'h0000_0000, "cycle-wrap");

        // Reset in the middle of operation
        rst_n = 1'b0;
        tick();
        readCheck(BASE,     32'h0, "led-midreset");
        readCheck(BASE + 6, 32'h0, "mask-midreset");
        readCheck(BASE + 7, 32'h0, "cycle-midreset");
        readCheck(BASE + 1, 32'h0, "sw-midreset");
        rst_n = 1'b1;
        repeat (4) tick();
        readCheck(BASE + 3, 32'h0, "key-edge-after-release");
        checkOutput(K_IRQ, 32'h0, "irq-after-release");
        tick();
        tick();
    endtask

    initial begin
        applyStimulus();
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard-drain: got %0d pending expectations required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mmio_periph_hub.md
Name: mmio_periph_hub

Overview:
- Parametrised memory-mapped peripheral layer between the CPU I/O bus and board/coprocessor signals.
- Provides an LED register, synchronised switch and key inputs, and sticky key-press event capture with write-1-to-clear (W1C).
- Provides a one-cycle coprocessor start pulse, a sticky coprocessor-done flag, a masked interrupt output and a free-running cycle counter.
- Sits between the CPU top and the FPGA pins / image coprocessor. Register offsets are consecutive addresses from BASE_ADDR.

Parameters:
- BITS, 32, data/address bus width
- BASE_ADDR, 32'hFFFFFFF0, address of offset 0
- NUM_LED, 10, LED outputs (≤ BITS)
- NUM_SW, 10, switch inputs (≤ BITS)
- NUM_KEY, 4, key inputs (≤ BITS-1)
- STS_W, 2, coprocessor status width
- DONE_BIT, 1, index of the status bit whose rising edge means "done"
- SYNC_STAGES, 2, synchroniser flops per async input (≥ 2)
- DEBOUNCE_CYCLES, 50000, stable cycles required (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- io_addr  in  BITS  I/O address
- io_wdata  in  BITS  write data
- io_wen  in  1  write strobe
- io_rden  in  1  read strobe
- io_rdata  out  BITS  read data, combinational
- sw  in  NUM_SW  async switches
- key  in  NUM_KEY  async keys, active-low (0 = pressed)
- ledr  out  NUM_LED  LED register
- coproc_ctl  out  8  start/command pulse
- coproc_sts  in  STS_W  coprocessor status
- irq  out  1  level interrupt

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
- Values after reset:
  - ledr = 0, key_edge = 0, irq_mask = 0, done_sticky = 0, cycle counter = 0, coproc_ctl = 0, irq = 0.
  - Synchroniser flops reset to 1 for keys (released) and 0 for switches.
- Reset mid-operation clears all state in the same edge. No pulse or edge event is generated from reset release.
- Register map (offset: access, content):
  - 0: RW, LED, io_wdata[NUM_LED-1:0].
  - 1: RO, SW, synchronised, zero-extended.
  - 2: RO, KEY level, synchronised/filtered, raw polarity.
  - 3: W1C, key_edge[NUM_KEY-1:0].
  - 4: WO, coproc_ctl.
  - 5: RO status / W1C. Read gives {done_sticky at bit 8, coproc_sts zero-extended}. Writing 1 to bit 8 clears done_sticky.
  - 6: RW, irq_mask[NUM_KEY:0]. Bit NUM_KEY masks done.
  - 7: RW, cycle counter. Write loads io_wdata.
- Address decode: hit requires io_addr == BASE_ADDR+offset, offset 0..7 exact.
- Reads:
  - Combinational, zero latency, gated by io_rden.
  - No rden, unmapped address, or write-only offset → io_rdata = 0.
- Writes: take effect on the clk edge while io_wen=1. Writes to RO offsets and unmapped addresses are ignored.
- coproc_ctl:
  - Combinational io_wdata[7:0] while offset 4 is written; 0 otherwise.
  - Exactly one cycle per write cycle. Back-to-back writes produce back-to-back pulses.
- Key edge capture: key_edge[i] sets when the filtered key goes from 1 to 0 (press).
- Done capture: done_sticky sets on a 0→1 transition of the registered coproc_sts[DONE_BIT].
- Set/clear collisions: if a set and a W1C clear occur in the same cycle, set wins (bit stays 1).
- Key latency: a key press reaches the KEY register SYNC_STAGES cycles after the pin changes; key_edge sets 1 cycle later.
- Cycle counter: increments every cycle and wraps from 2^BITS-1 to 0. A load in a cycle replaces that cycle's increment.
- irq: registered; irq = |({done_sticky, key_edge} & irq_mask), valid one cycle after its sources change.

Optional Feature:
- Macro MMIO_DEBOUNCE_EN.
- Defined: each synchronised key passes through a debouncer. The filtered level changes only after the input differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any bounce. Edge detection uses the filtered level.
- Undefined: filtered level = synchronised level; DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package common_params:
  - BITS.
  - Enum of register offsets: LED, SW, KEY, KEY_EDGE, COPROC_CTL, COPROC_STS, IRQ_MASK, CYCLE.
  - DONE_STICKY_BIT = 8 localparam.
- Sub-module mmio_debounce: one instance per key, containing synchroniser + optional filter + falling-edge output.

Test Plan:
- Write 0x3FF to BASE → ledr = 0x3FF next cycle. Write with io_wen=0 → no change. Reset → ledr = 0.
- sw = 0x155 held → read at BASE+1 returns 0x155 only once SYNC_STAGES cycles have elapsed; earlier reads return 0.
- Drive key[2] low (macro off) → key_edge = 0x4 after SYNC_STAGES+1 cycles; irq stays 0 with mask = 0. Write mask = 0x4 → irq = 1. W1C 0x4 in the same cycle as a new key[2] press → bit stays 1.
- Write 0x81 to BASE+4 twice back-to-back → coproc_ctl = 0x81 for exactly 2 cycles, then 0.
- coproc_sts 0→2 → status read = 0x102. Write 0x100 to BASE+5 → read = 0x002. With mask bit 4 set, irq follows done_sticky.
- Load 0xFFFFFFFE to BASE+7 → reads 0xFFFFFFFF then 0x0 on following cycles.
- With MMIO_DEBOUNCE_EN and DEBOUNCE_CYCLES = 8: key low for 5 cycles, high for 1, low for 8 → exactly one edge, after the 8-cycle run.
